// File: rtl/buf_seq_if.sv
// Stream / buffer-controller signal bundle for buf_seq.
// slave is the sequencer's view; master is the view of whatever surrounds it
// (upstream FFT stage, buf_ctl and the downstream consumer together).
interface buf_seq_if;
    // control
    logic        start;
    logic        busy;
    logic        done;
    // upstream pair stream
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data0;
    logic [63:0] in_data1;
    // buf_ctl access
    logic        mem_wr;
    logic        mem_rd;
    logic [6:0]  row_no;
    logic [6:0]  col_no;
    logic [6:0]  dep_no;
    logic [63:0] mem_wrdata0;
    logic [63:0] mem_wrdata1;
    logic [63:0] mem_rddata0;
    logic [63:0] mem_rddata1;
    // downstream pair stream
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data0;
    logic [63:0] out_data1;

    modport slave (
        input  start, in_valid, in_data0, in_data1,
        input  mem_rddata0, mem_rddata1, out_ready,
        output busy, done, in_ready,
        output mem_wr, mem_rd, row_no, col_no, dep_no, mem_wrdata0, mem_wrdata1,
        output out_valid, out_data0, out_data1
    );

    modport master (
        output start, in_valid, in_data0, in_data1,
        output mem_rddata0, mem_rddata1, out_ready,
        input  busy, done, in_ready,
        input  mem_wr, mem_rd, row_no, col_no, dep_no, mem_wrdata0, mem_wrdata1,
        input  out_valid, out_data0, out_data1
    );
endinterface

// File: rtl/buf_seq.sv
// Frame sequencer for the 3-D FFT transpose buffer: one write sweep of a
// CUBIC_D^3 cube as pairs, then one read sweep whose returned data is staged
// through a credit-managed skid FIFO sized to cover the memory read latency.
module buf_seq #(
    parameter int CUBIC_D    = 96,  // even, <= 128
    parameter int RD_LAT     = 2,   // 1..3
    parameter int FIFO_DEPTH = 4    // >= RD_LAT + 1
) (
    input  logic     clk,
    input  logic     rst_n,
    buf_seq_if.slave bus
);
    localparam int IW   = 7;
    localparam int HALF = CUBIC_D / 2;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int OW   = 8;        // holds fifo_cnt + in-flight reads

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DRAIN} state_t;

    state_t           state;
    logic             done_q;
    logic [IW-1:0]    row_q, col_q, dep_q;
    logic [RD_LAT:1]  vld_pipe;     // stage k: read issued k cycles ago
    logic [63:0]      fifo_d0 [FIFO_DEPTH];
    logic [63:0]      fifo_d1 [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    fifo_cnt;

    logic             wr_xfer, rd_xfer, xfer, last_idx;
    logic             push, pop, drain_empty;
    logic [OW-1:0]    inflight, occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit accounting: a read is only issued when its data is guaranteed a
    // FIFO slot, counting reads still in the memory pipeline and a pop this cycle.
    always_comb begin
        inflight = '0;
        for (int k = 1; k <= RD_LAT; k++)
            inflight = inflight + OW'(vld_pipe[k]);
        pop         = (fifo_cnt != '0) && bus.out_ready;
        push        = vld_pipe[RD_LAT];
        occ         = OW'(fifo_cnt) + inflight - OW'(pop);
        wr_xfer     = (state == S_WR) && bus.in_valid;
        rd_xfer     = (state == S_RD) && (occ < OW'(FIFO_DEPTH));
        xfer        = wr_xfer || rd_xfer;
        last_idx    = (row_q == IW'(HALF - 1)) && (col_q == IW'(CUBIC_D - 1)) &&
                      (dep_q == IW'(CUBIC_D - 1));
        drain_empty = (fifo_cnt == '0) && (inflight == '0);
    end

    assign bus.in_ready    = (state == S_WR);
    assign bus.mem_wr      = wr_xfer;
    assign bus.mem_rd      = rd_xfer;
    assign bus.row_no      = row_q;
    assign bus.col_no      = col_q;
    assign bus.dep_no      = dep_q;
    assign bus.mem_wrdata0 = bus.in_data0;
    assign bus.mem_wrdata1 = bus.in_data1;
    assign bus.out_valid   = (fifo_cnt != '0);
    assign bus.out_data0   = fifo_d0[rd_ptr];
    assign bus.out_data1   = fifo_d1[rd_ptr];
    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = done_q;

    // Frame FSM; done is raised for the single cycle in which IDLE is re-entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE:  if (bus.start)         state <= S_WR;
                S_WR:    if (wr_xfer && last_idx) state <= S_RD;
                S_RD:    if (rd_xfer && last_idx) state <= S_DRAIN;
                S_DRAIN: if (drain_empty) begin
                             state  <= S_IDLE;
                             done_q <= 1'b1;
                         end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Shared pair index counter: row innermost, then col, then dep; it wraps to
    // zero on the last pair of a sweep, so the read sweep starts at (0,0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            dep_q <= '0;
        end else if (xfer) begin
            if (row_q == IW'(HALF - 1)) begin
                row_q <= '0;
                if (col_q == IW'(CUBIC_D - 1)) begin
                    col_q <= '0;
                    dep_q <= (dep_q == IW'(CUBIC_D - 1)) ? '0 : dep_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end else begin
                row_q <= row_q + 1'b1;
            end
        end
    end

    // In-flight read tracker; the last stage lines up with valid mem_rddata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_xfer;
            for (int k = 2; k <= RD_LAT; k++)
                vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    // FIFO storage; no reset needed since occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_d0[wr_ptr] <= bus.mem_rddata0;
            fifo_d1[wr_ptr] <= bus.mem_rddata1;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop both take effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
endmodule
